// File: rtl/minterm_pkg.sv
// Shared types and helpers for the minterm lister: the FSM state encoding
// and the "no higher set bit" test used to flag the final minterm.
package minterm_pkg;

    localparam int N_VARS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        DONE
    } state_t;

    // True when no bit of tt above position idx is set; sized for the widest legal table (N_VARS=6).
    function automatic logic none_above(input logic [63:0] tt, input logic [5:0] idx);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if ((i > int'(idx)) && tt[i]) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/minterm_lister_if.sv
// Truth-table load channel plus minterm output stream for the minterm lister.
// The slave modport is the lister itself; the master side is the table source and index sink.
interface minterm_lister_if
    import minterm_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEFAULT
);
    localparam int TT_W = 2 ** N_VARS;

    logic              tt_valid;
    logic              tt_ready;
    logic [TT_W-1:0]   tt_data;
    logic              m_valid;
    logic              m_ready;
    logic [N_VARS-1:0] m_index;
    logic              m_last;
    logic [N_VARS:0]   m_count;
    logic              done;

    modport master (
        output tt_valid, tt_data, m_ready,
        input  tt_ready, m_valid, m_index, m_last, m_count, done
    );

    modport slave (
        input  tt_valid, tt_data, m_ready,
        output tt_ready, m_valid, m_index, m_last, m_count, done
    );

endinterface

// File: rtl/minterm_popcount.sv
// Combinational population count of a truth table; one extra output bit so
// that an all-ones table (count == TT_W) is representable.
module minterm_popcount #(
    parameter int N_VARS = 4
) (
    input  logic [2**N_VARS-1:0] tt,
    output logic [N_VARS:0]      count
);
    localparam int CW = N_VARS + 1;

    always_comb begin
        count = '0;
        for (int i = 0; i < 2 ** N_VARS; i++) begin
            count = count + CW'(tt[i]);
        end
    end

endmodule

// File: rtl/minterm_lister.sv
// Latches a truth table, scans it one bit per cycle and streams the indices of
// the set bits in ascending order, flagging the last one and pulsing done at the end.
module minterm_lister
    import minterm_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    minterm_lister_if.slave bus
);
    localparam int TT_W = 2 ** N_VARS;
    localparam logic [N_VARS-1:0] IDX_MAX = N_VARS'(TT_W - 1);

    state_t            state_q, state_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [N_VARS-1:0] idx_q, idx_d;
    logic              tt_ready_q, tt_ready_d;
    logic              m_valid_q, m_valid_d;
    logic [N_VARS-1:0] m_index_q, m_index_d;
    logic              m_last_q, m_last_d;
    logic [N_VARS:0]   m_count_q, m_count_d;
    logic              done_q, done_d;
    logic [N_VARS:0]   pop;

    minterm_popcount #(.N_VARS(N_VARS)) u_popcount (
        .tt    (bus.tt_data),
        .count (pop)
    );

    always_comb begin
        state_d    = state_q;
        tt_d       = tt_q;
        idx_d      = idx_q;
        tt_ready_d = tt_ready_q;
        m_valid_d  = m_valid_q;
        m_index_d  = m_index_q;
        m_last_d   = m_last_q;
        m_count_d  = m_count_q;
        done_d     = done_q;

        case (state_q)
            IDLE: begin
                if (bus.tt_valid && tt_ready_q) begin
                    tt_d       = bus.tt_data;
                    m_count_d  = pop;
                    idx_d      = '0;
                    tt_ready_d = 1'b0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (tt_q[idx_q]) begin
                    m_valid_d = 1'b1;
                    m_index_d = idx_q;
                    m_last_d  = none_above(64'(tt_q), 6'(idx_q));
                    state_d   = EMIT;
                end else if (idx_q == IDX_MAX) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            EMIT: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (m_last_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        // A non-last emission guarantees a higher set bit, so idx cannot pass IDX_MAX.
                        idx_d   = idx_q + 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                done_d     = 1'b0;
                tt_ready_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d    = IDLE;
                tt_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tt_q       <= '0;
            idx_q      <= '0;
            tt_ready_q <= 1'b1;
            m_valid_q  <= 1'b0;
            m_index_q  <= '0;
            m_last_q   <= 1'b0;
            m_count_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tt_q       <= tt_d;
            idx_q      <= idx_d;
            tt_ready_q <= tt_ready_d;
            m_valid_q  <= m_valid_d;
            m_index_q  <= m_index_d;
            m_last_q   <= m_last_d;
            m_count_q  <= m_count_d;
            done_q     <= done_d;
        end
    end

    assign bus.tt_ready = tt_ready_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_index  = m_index_q;
    assign bus.m_last   = m_last_q;
    assign bus.m_count  = m_count_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_minterm_lister.sv
// Bench for minterm_lister (N_VARS=4): directed and random tables, streams
// collected at the falling edge and compared against a list-of-set-bits model.
module tb_minterm_lister;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    minterm_lister_if #(.N_VARS(4)) bus ();

    minterm_lister #(.N_VARS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef int iq_t[$];

    // Reference: ascending list of positions where the table is 1.
    function automatic iq_t model(input logic [15:0] tt);
        iq_t q;
        for (int i = 0; i < 16; i++) if (tt[i]) q.push_back(i);
        return q;
    endfunction

    int   obs_idx[$];
    bit   obs_last[$];
    int   done_cnt, done_e, first_e, stab_err, gap_err, ready_err, cnt_at_done;
    bit   timeout, after_ready;

    // Loads one table and records the resulting stream; called aligned to a falling edge.
    task automatic run_stream(input logic [15:0] tt, input int mode, input bit hold, input logic [15:0] next_tt);
        int e, guard;
        bit pend, hs_prev;
        logic [3:0] pidx;
        logic plast;
        obs_idx.delete(); obs_last.delete();
        done_cnt = 0; done_e = -1; first_e = -1; stab_err = 0; gap_err = 0;
        ready_err = 0; cnt_at_done = -1; timeout = 0; after_ready = 0;
        guard = 0;
        while (!bus.tt_ready && guard < 100) begin @(negedge clk); guard++; end
        if (!bus.tt_ready) timeout = 1;
        bus.tt_valid = 1'b1;
        bus.tt_data  = tt;
        @(posedge clk); #1;
        if (hold) bus.tt_data = next_tt; else bus.tt_valid = 1'b0;
        e = 0; pend = 0; hs_prev = 0; pidx = '0; plast = 1'b0;
        while (done_cnt == 0 && e < 400) begin
            @(negedge clk); e++;
            if (bus.tt_ready) ready_err++;
            if (pend && (!bus.m_valid || bus.m_index !== pidx || bus.m_last !== plast)) stab_err++;
            if (hs_prev && bus.m_valid) gap_err++;
            if (bus.m_valid && first_e < 0) first_e = e;
            if (bus.done) begin done_cnt++; done_e = e; cnt_at_done = int'(bus.m_count); end
            case (mode)
                0: bus.m_ready = 1'b1;
                1: bus.m_ready = (e % 2) == 1;
                default: bus.m_ready = 1'($urandom_range(0, 1));
            endcase
            hs_prev = bus.m_valid && bus.m_ready;
            pend    = bus.m_valid && !bus.m_ready;
            pidx    = bus.m_index;
            plast   = bus.m_last;
            if (hs_prev) begin obs_idx.push_back(int'(bus.m_index)); obs_last.push_back(bus.m_last); end
        end
        if (done_cnt == 0) timeout = 1;
        @(negedge clk);
        if (bus.done) done_cnt++;
        after_ready = bus.tt_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.tt_valid = 1'b0; bus.tt_data = '0; bus.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.tt_ready !== 1'b1) begin failures++; $display("FAIL reset_tt_ready got %b want 1", bus.tt_ready); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got %b want 0", bus.m_valid); end
        checks++; if (bus.m_count !== 5'd0) begin failures++; $display("FAIL reset_m_count got %0d want 0", bus.m_count); end
        checks++; if ({bus.m_index, bus.m_last, bus.done} !== 6'd0) begin failures++; $display("FAIL reset_misc got %b want 0", {bus.m_index, bus.m_last, bus.done}); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: tt_ready=%b m_valid=%b m_count=%0d", bus.tt_ready, bus.m_valid, bus.m_count);
    endtask

    task automatic test_stream(input string name, input logic [15:0] tt, input int mode);
        iq_t exp;
        int nlast;
        exp = model(tt);
        run_stream(tt, mode, 1'b0, 16'h0);
        $display("%s: tt=%h mode=%0d emitted=%0d count=%0d first_e=%0d done_e=%0d", name, tt, mode, obs_idx.size(), cnt_at_done, first_e, done_e);
        checks++; if (timeout) begin failures++; $display("FAIL %s_timeout got 1 want 0", name); end
        checks++; if (obs_idx.size() != exp.size()) begin failures++; $display("FAIL %s_len got %0d want %0d", name, obs_idx.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs_idx.size(); i++) begin
            checks++; if (obs_idx[i] != exp[i]) begin failures++; $display("FAIL %s_idx[%0d] got %0d want %0d", name, i, obs_idx[i], exp[i]); end
        end
        nlast = 0;
        foreach (obs_last[i]) if (obs_last[i]) nlast++;
        checks++; if (nlast != (exp.size() > 0 ? 1 : 0)) begin failures++; $display("FAIL %s_last_cnt got %0d want %0d", name, nlast, exp.size() > 0 ? 1 : 0); end
        if (obs_last.size() > 0) begin
            checks++; if (obs_last[obs_last.size()-1] !== 1'b1) begin failures++; $display("FAIL %s_last_final got 0 want 1", name); end
        end
        checks++; if (cnt_at_done != exp.size()) begin failures++; $display("FAIL %s_m_count got %0d want %0d", name, cnt_at_done, exp.size()); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL %s_done_pulses got %0d want 1", name, done_cnt); end
        checks++; if (stab_err != 0 || gap_err != 0) begin failures++; $display("FAIL %s_handshake got stab=%0d gap=%0d want 0", name, stab_err, gap_err); end
        checks++; if (ready_err != 0 || after_ready !== 1'b1) begin failures++; $display("FAIL %s_tt_ready got busy_hi=%0d after=%b want 0/1", name, ready_err, after_ready); end
        if (exp.size() > 0) begin
            checks++; if (first_e != exp[0] + 2) begin failures++; $display("FAIL %s_first_latency got %0d want %0d", name, first_e, exp[0] + 2); end
        end else begin
            checks++; if (first_e != -1 || done_e != 17) begin failures++; $display("FAIL %s_zero_timing got first=%0d done=%0d want -1/17", name, first_e, done_e); end
        end
    endtask

    task automatic test_reset_mid_stream();
        int guard;
        bus.m_ready = 1'b1;
        bus.tt_valid = 1'b1; bus.tt_data = 16'h5516;
        @(posedge clk); #1; bus.tt_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!(bus.m_valid && bus.m_index == 4'd4) && guard < 100) begin @(negedge clk); guard++; end
        checks++; if (!(bus.m_valid && bus.m_index == 4'd4)) begin failures++; $display("FAIL rst_mid_reach got idx=%0d want 4", bus.m_index); end
        bus.m_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        $display("rst_mid: tt_ready=%b m_valid=%b m_index=%0d m_count=%0d", bus.tt_ready, bus.m_valid, bus.m_index, bus.m_count);
        checks++; if ({bus.tt_ready, bus.m_valid, bus.m_last, bus.done} !== 4'b1000) begin failures++; $display("FAIL rst_mid_flags got %b want 1000", {bus.tt_ready, bus.m_valid, bus.m_last, bus.done}); end
        checks++; if (bus.m_index !== 4'd0 || bus.m_count !== 5'd0) begin failures++; $display("FAIL rst_mid_values got idx=%0d cnt=%0d want 0/0", bus.m_index, bus.m_count); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done got 1 want 0"); end
        end
        test_stream("reload_5516", 16'h5516, 0);
    endtask

    task automatic test_back_to_back();
        iq_t exp;
        logic [15:0] second;
        second = 16'h0C21;
        exp = model(16'h5516);
        run_stream(16'h5516, 0, 1'b1, second);
        $display("b2b_first: emitted=%0d count=%0d busy_ready=%0d", obs_idx.size(), cnt_at_done, ready_err);
        checks++; if (obs_idx.size() != exp.size()) begin failures++; $display("FAIL b2b_first_len got %0d want %0d", obs_idx.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < obs_idx.size(); i++) begin
            checks++; if (obs_idx[i] != exp[i]) begin failures++; $display("FAIL b2b_first_idx[%0d] got %0d want %0d", i, obs_idx[i], exp[i]); end
        end
        checks++; if (cnt_at_done != 7) begin failures++; $display("FAIL b2b_first_count got %0d want 7", cnt_at_done); end
        checks++; if (ready_err != 0) begin failures++; $display("FAIL b2b_busy_ready got %0d want 0", ready_err); end
        test_stream("b2b_second", second, 0);
    endtask

    task automatic test_random();
        logic [15:0] tt;
        for (int n = 0; n < 6; n++) begin
            tt = 16'($urandom);
            if (n == 0) tt = tt & 16'hF0F0;
            test_stream($sformatf("rand%0d", n), tt, 2);
        end
    endtask

    initial begin
        test_reset();
        test_stream("ex_5516", 16'h5516, 0);
        test_stream("zero", 16'h0000, 0);
        test_stream("ones_toggle", 16'hFFFF, 1);
        test_stream("top_bit", 16'h8000, 0);
        test_stream("bottom_bit", 16'h0001, 0);
        test_reset_mid_stream();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
